// File: rtl/dmi_cmd_initiator.sv
// dmi_cmd_initiator: buffered DMI request initiator with busy retry,
// response watchdog and stale-response drop.
module dmi_cmd_initiator #(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int MAX_RETRIES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [6:0]  cmd_addr_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_status_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_bits_addr_o,
  output logic [1:0]  dmi_req_bits_op_o,
  output logic [31:0] dmi_req_bits_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [1:0]  dmi_resp_bits_resp_i,
  input  logic [31:0] dmi_resp_bits_data_i,
  output logic        busy_o
);

  localparam int AW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(CMD_FIFO_DEPTH);
  localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRIES);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_TMO  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_BUSY = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DELIVER
  } state_t;

  state_t        state;
  logic          stale;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timer;

  logic [40:0]   mem [CMD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [40:0]   head;

  logic          req_fire;
  logic          resp_fire;
  logic          resp_busy;
  logic          resp_ok;

  assign full        = (count == DEPTH_L);
  assign empty       = (count == '0);
  assign cmd_ready_o = !full && !rst_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state == IDLE) && !empty && !stale;
  assign head        = mem[rd_ptr];

  assign req_fire  = dmi_req_valid_o && dmi_req_ready_i;
  assign resp_fire = dmi_resp_valid_i && dmi_resp_ready_o;
  assign resp_busy = (dmi_resp_bits_resp_i == 2'd3);
  assign resp_ok   = (dmi_resp_bits_resp_i == 2'd0);

  assign busy_o = (state != IDLE) || !empty || stale;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_addr_i, cmd_op_i, cmd_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      stale               <= 1'b0;
      retry_cnt           <= '0;
      timer               <= '0;
      dmi_req_valid_o     <= 1'b0;
      dmi_req_bits_addr_o <= '0;
      dmi_req_bits_op_o   <= '0;
      dmi_req_bits_data_o <= '0;
      dmi_resp_ready_o    <= 1'b0;
      rsp_valid_o         <= 1'b0;
      rsp_data_o          <= '0;
      rsp_status_o        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {dmi_req_bits_addr_o,
             dmi_req_bits_op_o,
             dmi_req_bits_data_o} <= head;
            retry_cnt       <= '0;
            dmi_req_valid_o <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (req_fire) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
            timer            <= '0;
            state            <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // a response in the expiry cycle still wins over the watchdog
          if (resp_fire) begin
            rsp_data_o       <= dmi_resp_bits_data_i;
            dmi_resp_ready_o <= 1'b0;
            if (resp_busy && retry_cnt < RMAX) begin
              retry_cnt       <= retry_cnt + 1'b1;
              dmi_req_valid_o <= 1'b1;
              state           <= REQ;
            end else begin
              unique case (1'b1)
                resp_ok:   rsp_status_o <= ST_OK;
                resp_busy: rsp_status_o <= ST_BUSY;
                default:   rsp_status_o <= ST_FAIL;
              endcase
              rsp_valid_o <= 1'b1;
              state       <= DELIVER;
            end
          end else if (timer == TLAST) begin
            rsp_status_o <= ST_TMO;
            rsp_data_o   <= '0;
            rsp_valid_o  <= 1'b1;
            stale        <= 1'b1;
            state        <= DELIVER;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DELIVER: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // the late answer to a timed-out request is swallowed here
      if (stale && state != WAIT_RSP && resp_fire) begin
        stale            <= 1'b0;
        dmi_resp_ready_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmi_cmd_initiator.sv
// Bench for dmi_cmd_initiator: scripted DMI responder, results
// scoreboarded against a model derived from each command's plan.
module tb_dmi_cmd_initiator;

  localparam int DEPTH = 4;
  localparam int MAXR  = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [6:0]  cmd_addr_i;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_status_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [6:0]  dmi_req_bits_addr_o;
  logic [1:0]  dmi_req_bits_op_o;
  logic [31:0] dmi_req_bits_data_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [1:0]  dmi_resp_bits_resp_i;
  logic [31:0] dmi_resp_bits_data_i;
  logic        busy_o;

  dmi_cmd_initiator #(
    .CMD_FIFO_DEPTH(DEPTH),
    .MAX_RETRIES   (MAXR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_addr_i          (cmd_addr_i),
    .cmd_op_i            (cmd_op_i),
    .cmd_data_i          (cmd_data_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_data_o          (rsp_data_o),
    .rsp_status_o        (rsp_status_o),
    .dmi_req_valid_o     (dmi_req_valid_o),
    .dmi_req_ready_i     (dmi_req_ready_i),
    .dmi_req_bits_addr_o (dmi_req_bits_addr_o),
    .dmi_req_bits_op_o   (dmi_req_bits_op_o),
    .dmi_req_bits_data_o (dmi_req_bits_data_o),
    .dmi_resp_valid_i    (dmi_resp_valid_i),
    .dmi_resp_ready_o    (dmi_resp_ready_o),
    .dmi_resp_bits_resp_i(dmi_resp_bits_resp_i),
    .dmi_resp_bits_data_i(dmi_resp_bits_data_i),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
    int          busy;
    logic [1:0]  fresp;
    logic [31:0] fdata;
    logic [31:0] bdata;
    bit          tmo;
    int          dly;
  } plan_t;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] data;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  bit    resp_en  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input plan_t p);
    exp_t e;
    if (p.busy > MAXR) begin
      e.status = 2'b11;
      e.data   = p.bdata;
    end else if (p.tmo) begin
      e.status = 2'b01;
      e.data   = 32'h0;
    end else if (p.fresp == 2'd0) begin
      e.status = 2'b00;
      e.data   = p.fdata;
    end else begin
      e.status = 2'b10;
      e.data   = p.fdata;
    end
    return e;
  endfunction

  function automatic plan_t mk(input logic [6:0] a, input logic [1:0] o,
                               input logic [31:0] d, input int busy,
                               input logic [1:0] fr, input logic [31:0] fd,
                               input bit tmo, input int dly);
    plan_t p;
    p.addr  = a;
    p.op    = o;
    p.data  = d;
    p.busy  = busy;
    p.fresp = fr;
    p.fdata = fd;
    p.bdata = 32'hB0B0_0000 ^ d;
    p.tmo   = tmo;
    p.dly   = dly;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.addr  = 7'($urandom);
    p.op    = 2'($urandom);
    p.data  = $urandom;
    p.busy  = ($urandom_range(0, 9) == 0) ? MAXR + 1 : $urandom_range(0, 2);
    p.fresp = 2'($urandom_range(0, 2));
    p.fdata = $urandom;
    p.bdata = $urandom;
    p.tmo   = ($urandom_range(0, 7) == 0);
    p.dly   = $urandom_range(0, 3);
    return p;
  endfunction

  task automatic send(input plan_t p, input bit track);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = p.addr;
    cmd_op_i    = p.op;
    cmd_data_i  = p.data;
    while (!cmd_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: ready stayed 0 for %0d cycles, required 1", n);
    end else if (track) begin
      plan_q.push_back(p);
      exp_q.push_back(model(p));
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drive_resp(input logic [1:0] r, input logic [31:0] d,
                            input int dly);
    repeat (dly) @(negedge clk);
    dmi_resp_valid_i     = 1'b1;
    dmi_resp_bits_resp_i = r;
    dmi_resp_bits_data_i = d;
    chk("resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    @(negedge clk);
    dmi_resp_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((plan_q.size() != 0 || exp_q.size() != 0 || rsp_valid_o)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d plans, %0d results pending after %0d cycles",
               plan_q.size(), exp_q.size(), n);
    end
    @(negedge clk);
    chk("drain_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin : responder
    plan_t cur;
    int nbusy = 0;
    int nreq  = 0;
    int k;
    dmi_req_ready_i      = 1'b0;
    dmi_resp_valid_i     = 1'b0;
    dmi_resp_bits_resp_i = 2'd0;
    dmi_resp_bits_data_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) continue;
      if (!dmi_req_valid_o) begin
        dmi_req_ready_i = 1'b0;
        continue;
      end
      if (plan_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_unexpected: request addr %0h with no command queued",
                 dmi_req_bits_addr_o);
        dmi_req_ready_i = 1'b0;
        continue;
      end
      cur = plan_q[0];
      chk("req_payload",
          64'({dmi_req_bits_addr_o, dmi_req_bits_op_o, dmi_req_bits_data_o}),
          64'({cur.addr, cur.op, cur.data}));
      dmi_req_ready_i = (rdy_mode == 1) ? 1'b1 :
                        (rdy_mode == 2) ? 1'b0 :
                        ($urandom_range(0, 2) != 0);
      if (!dmi_req_ready_i) continue;
      nreq++;
      @(negedge clk);
      dmi_req_ready_i = 1'b0;
      if (nbusy < cur.busy) begin
        drive_resp(2'd3, cur.bdata, cur.dly);
        nbusy++;
        if (nbusy <= MAXR) begin
          chk("retry_reissue", 64'(dmi_req_valid_o), 64'd1);
          continue;
        end
        chk("rsp_latency", 64'(rsp_valid_o), 64'd1);
      end else if (cur.tmo) begin
        k = 1;
        while (!rsp_valid_o && k < 40) begin
          @(negedge clk);
          k++;
        end
        chk("timeout_cycles", 64'(k), 64'(TMO + 1));
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          chk("stale_hold", 64'(dmi_req_valid_o), 64'd0);
        end
        drive_resp(2'($urandom), $urandom, 0);
      end else begin
        drive_resp(cur.fresp, cur.fdata, cur.dly);
        chk("rsp_latency", 64'(rsp_valid_o), 64'd1);
      end
      chk("req_count", 64'(nreq),
          64'((cur.busy > MAXR) ? MAXR + 1 : cur.busy + 1));
      void'(plan_q.pop_front());
      nbusy = 0;
      nreq  = 0;
    end
  end

  initial begin : monitor
    exp_t e;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: status %0h data %0h, none expected",
                   rsp_status_o, rsp_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_status", 64'(rsp_status_o), 64'(e.status));
          chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end

  initial begin : main
    int k;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_op_i    = '0;
    cmd_data_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_data_o}), 64'd0);
    chk("rst_req", 64'({dmi_req_valid_o, dmi_req_bits_addr_o,
                        dmi_req_bits_op_o, dmi_req_bits_data_o}), 64'd0);
    chk("rst_misc", 64'({dmi_resp_ready_o, busy_o}), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cmd_ready_o), 64'd1);

    rdy_mode = 1;
    send(mk(7'h11, 2'd1, 32'h0, 0, 2'd0, 32'hDEADBEEF, 1'b0, 3), 1'b1);
    chk("issue_c1", 64'(dmi_req_valid_o), 64'd0);
    @(negedge clk);
    chk("issue_c2", 64'(dmi_req_valid_o), 64'd1);
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 5; i++)
      send(mk(7'(32 + i), 2'd2, 32'h1000_0000 + 32'(i), 0, 2'd0,
              32'hA0 + 32'(i), 1'b0, 1), 1'b1);
    chk("fifo_full", 64'(cmd_ready_o), 64'd0);
    chk("busy_active", 64'(busy_o), 64'd1);
    fork
      send(mk(7'h40, 2'd2, 32'h2000_0000, 0, 2'd0, 32'hB5, 1'b0, 0), 1'b1);
      begin
        repeat (8) @(negedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();

    send(mk(7'h12, 2'd1, 32'h0, 2, 2'd0, 32'h1234_5678, 1'b0, 1), 1'b1);
    send(mk(7'h13, 2'd2, 32'h55AA, MAXR + 1, 2'd0, 32'h0, 1'b0, 0), 1'b1);
    wait_drain();

    send(mk(7'h14, 2'd1, 32'h0, 0, 2'd0, 32'hFFFF, 1'b1, 0), 1'b1);
    send(mk(7'h15, 2'd0, 32'h0, 0, 2'd0, 32'h77, 1'b0, 2), 1'b1);
    wait_drain();

    send(mk(7'h16, 2'd1, 32'h0, 0, 2'd2, 32'h5, 1'b0, 0), 1'b1);
    send(mk(7'h17, 2'd3, 32'h9, 0, 2'd1, 32'h6, 1'b0, 1), 1'b1);
    wait_drain();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rdy_mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
      send(rand_plan(), 1'b1);
    end
    wait_drain();

    resp_en         = 1'b0;
    dmi_req_ready_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(rand_plan(), 1'b0);
    k = 0;
    while (!dmi_req_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    dmi_req_ready_i = 1'b1;
    @(negedge clk);
    dmi_req_ready_i = 1'b0;
    chk("wait_rsp_entered", 64'(dmi_resp_ready_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("mid_rst_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_data_o}), 64'd0);
    chk("mid_rst_req", 64'({dmi_req_valid_o, dmi_req_bits_addr_o,
                            dmi_req_bits_op_o, dmi_req_bits_data_o}), 64'd0);
    chk("mid_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_ready", 64'(cmd_ready_o), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("no_req_after_rst", 64'(dmi_req_valid_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
